// File: rtl/eth_speed_pkg.sv
// Shared speed encodings and the force-value mapping used by the link-speed
// detector and its consumers.
package eth_speed_pkg;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    // 2'b11 is not a legal speed code; it folds onto 1000M.
    function automatic logic [1:0] map_force_speed(input logic [1:0] fs);
        logic [1:0] res;
        if (fs == 2'b11) begin
            res = SPEED_1000M;
        end else begin
            res = fs;
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_speed_sync.sv
// N-flop single-bit synchronizer; exposes the last two stages so callers can
// detect transitions of the synchronized level.
module eth_speed_sync #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic prev_o
);

    logic [STAGES-1:0] sync_q;

    // Every stage is reset so the chain stays plain flops, never a shift-register primitive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign prev_o = sync_q[STAGES-2];

endmodule

// File: rtl/eth_speed_detect.sv
// Live 10/100/1000 link-speed detector: times a prescaled rx_clk toggle against
// gtx_clk, commits a speed after CONFIRM_COUNT agreeing windows, with a software override.
module eth_speed_detect
    import eth_speed_pkg::*;
#(
    parameter int unsigned REF_WIDTH     = 7,
    parameter int unsigned EDGE_WIDTH    = 2,
    parameter int unsigned THRESH_100M   = 32,
    parameter int unsigned CONFIRM_COUNT = 2,
    parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_prescale_toggle,
    input  logic       force_en,
    input  logic [1:0] force_speed,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_valid,
    output logic       speed_change
);

    localparam logic [REF_WIDTH-1:0] REF_ONE    = REF_WIDTH'(1'b1);
    localparam logic [REF_WIDTH-1:0] THRESH_REF = REF_WIDTH'(THRESH_100M);
    localparam logic [3:0]           CONF_MAX   = 4'hF;
    localparam logic [3:0]           CONF_NEED  = 4'(CONFIRM_COUNT);

    logic                  sync_s;
    logic                  sync_prev_s;
    logic                  edge_det_s;
    logic                  win_end_s;
    logic [1:0]            cand_s;
    logic                  commit_s;
    logic [REF_WIDTH-1:0]  ref_cnt_q,    ref_cnt_d;
    logic [EDGE_WIDTH-1:0] edge_cnt_q,   edge_cnt_d;
    logic [1:0]            last_cand_q,  last_cand_d;
    logic [3:0]            conf_cnt_q,   conf_cnt_d;
    logic [1:0]            meas_speed_q, meas_speed_d;
    logic                  meas_valid_q, meas_valid_d;
    logic [1:0]            speed_q,      speed_d;
    logic                  mii_select_q;
    logic                  speed_valid_q;
    logic                  speed_change_q;

    eth_speed_sync #(.STAGES(3)) u_rx_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (rx_prescale_toggle),
        .sync_o (sync_s),
        .prev_o (sync_prev_s)
    );

    assign edge_det_s = sync_prev_s ^ sync_s;
    assign win_end_s  = (&ref_cnt_q) | (&edge_cnt_q);

    // Classify a closing window; a full edge count wins over a full reference count.
    always_comb begin
        cand_s = SPEED_10M;
        if (&edge_cnt_q) begin
            if (ref_cnt_q >= THRESH_REF) begin
                cand_s = SPEED_100M;
            end else begin
                cand_s = SPEED_1000M;
            end
        end else begin
            cand_s = SPEED_10M;
        end
    end

    // Window counters restart on the closing edge, dropping that cycle's increments.
    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        edge_cnt_d = edge_cnt_q;
        if (win_end_s) begin
            ref_cnt_d  = '0;
            edge_cnt_d = '0;
        end else begin
            ref_cnt_d  = ref_cnt_q + REF_ONE;
            edge_cnt_d = edge_cnt_q + EDGE_WIDTH'(edge_det_s);
        end
    end

    // Run-length of identical candidates; commit once the run reaches CONFIRM_COUNT.
    always_comb begin
        last_cand_d = last_cand_q;
        conf_cnt_d  = conf_cnt_q;
        commit_s    = 1'b0;
        if (win_end_s) begin
            if (cand_s == last_cand_q) begin
                if (conf_cnt_q != CONF_MAX) begin
                    conf_cnt_d = conf_cnt_q + 4'd1;
                end else begin
                    conf_cnt_d = conf_cnt_q;
                end
            end else begin
                last_cand_d = cand_s;
                conf_cnt_d  = 4'd1;
            end
            commit_s = (conf_cnt_d >= CONF_NEED);
        end else begin
            commit_s = 1'b0;
        end
    end

    // Next committed speed and the value presented to the PHY/MAC.
    always_comb begin
        meas_speed_d = meas_speed_q;
        meas_valid_d = meas_valid_q | commit_s;
        if (commit_s) begin
            meas_speed_d = cand_s;
        end else begin
            meas_speed_d = meas_speed_q;
        end
        if (force_en) begin
            speed_d = map_force_speed(force_speed);
        end else begin
            speed_d = meas_speed_d;
        end
    end

    // All state; reset drops any partial window and partial confirmation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q      <= '0;
            edge_cnt_q     <= '0;
            last_cand_q    <= DEFAULT_SPEED;
            conf_cnt_q     <= 4'd0;
            meas_speed_q   <= DEFAULT_SPEED;
            meas_valid_q   <= 1'b0;
            speed_q        <= DEFAULT_SPEED;
            mii_select_q   <= (DEFAULT_SPEED != SPEED_1000M);
            speed_valid_q  <= 1'b0;
            speed_change_q <= 1'b0;
        end else begin
            ref_cnt_q      <= ref_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            last_cand_q    <= last_cand_d;
            conf_cnt_q     <= conf_cnt_d;
            meas_speed_q   <= meas_speed_d;
            meas_valid_q   <= meas_valid_d;
            speed_q        <= speed_d;
            mii_select_q   <= (speed_d != SPEED_1000M);
            speed_valid_q  <= meas_valid_d | force_en;
            speed_change_q <= (speed_d != speed_q);
        end
    end

    assign speed        = speed_q;
    assign mii_select   = mii_select_q;
    assign speed_valid  = speed_valid_q;
    assign speed_change = speed_change_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Randomized bench for eth_speed_detect: two instances (CONFIRM_COUNT 2 and 1)
// compared every cycle against a window/run-length model, plus directed literal checks.
module tb_eth_speed_detect;

    localparam int RMAX   = 127;
    localparam int EMAX   = 3;
    localparam int THRESH = 32;
    localparam int DEF    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tog = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_speed = 2'b00;
    logic [1:0] speed_a, speed_b;
    logic       mii_a, mii_b, valid_a, valid_b, chg_a, chg_b;

    int checks = 0;
    int errors = 0;

    int half = 0;
    bit tog_zero = 1'b0;
    int gaps[$];
    int chg_cnt[2];

    // model state
    int smp[3];
    int win_cycles, win_edges;
    int run[2], last[2], meas[2];
    bit committed[2];
    int exp_speed[2], exp_mii[2], exp_valid[2], exp_chg[2];
    int conf_par[2];

    always #5 clk = ~clk;

    eth_speed_detect dut_a (
        .clk(clk), .rst_n(rst_n), .rx_prescale_toggle(tog),
        .force_en(force_en), .force_speed(force_speed),
        .speed(speed_a), .mii_select(mii_a), .speed_valid(valid_a), .speed_change(chg_a)
    );

    eth_speed_detect #(.CONFIRM_COUNT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_prescale_toggle(tog),
        .force_en(force_en), .force_speed(force_speed),
        .speed(speed_b), .mii_select(mii_b), .speed_valid(valid_b), .speed_change(chg_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) smp[i] = 0;
        win_cycles = 0;
        win_edges  = 0;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; last[i] = DEF; meas[i] = DEF; committed[i] = 1'b0;
            exp_speed[i] = DEF; exp_mii[i] = 0; exp_valid[i] = 0; exp_chg[i] = 0;
        end
    endtask

    // One reference-clock period of the speed rules, applied to pre-edge inputs.
    task automatic model_step();
        int edge_now, cand, nsp;
        bit closing, commit;
        edge_now = smp[1] ^ smp[2];
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = int'(tog);
        closing = (win_edges >= EMAX) || (win_cycles >= RMAX);
        if (win_edges >= EMAX) cand = (win_cycles >= THRESH) ? 1 : 2;
        else cand = 0;
        if (closing) begin
            win_cycles = 0;
            win_edges  = 0;
        end else begin
            win_cycles++;
            win_edges += edge_now;
        end
        for (int i = 0; i < 2; i++) begin
            commit = 1'b0;
            if (closing) begin
                run[i]  = (cand == last[i]) ? run[i] + 1 : 1;
                last[i] = cand;
                commit  = (run[i] >= conf_par[i]);
                if (commit) begin
                    meas[i] = cand;
                    committed[i] = 1'b1;
                end
            end
            if (force_en) nsp = (force_speed == 2'b11) ? 2 : int'(force_speed);
            else nsp = meas[i];
            exp_chg[i]   = (nsp != exp_speed[i]) ? 1 : 0;
            exp_speed[i] = nsp;
            exp_mii[i]   = (nsp != 2) ? 1 : 0;
            exp_valid[i] = (committed[i] || force_en) ? 1 : 0;
        end
    endtask

    initial begin
        conf_par[0] = 2;
        conf_par[1] = 1;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        chg_cnt[0] = 0;
        chg_cnt[1] = 0;
        forever begin
            @(negedge clk);
            chk("cmp_speed_a", int'(speed_a), exp_speed[0]);
            chk("cmp_mii_a",   int'(mii_a),   exp_mii[0]);
            chk("cmp_valid_a", int'(valid_a), exp_valid[0]);
            chk("cmp_chg_a",   int'(chg_a),   exp_chg[0]);
            chk("cmp_speed_b", int'(speed_b), exp_speed[1]);
            chk("cmp_mii_b",   int'(mii_b),   exp_mii[1]);
            chk("cmp_valid_b", int'(valid_b), exp_valid[1]);
            chk("cmp_chg_b",   int'(chg_b),   exp_chg[1]);
            chg_cnt[0] += int'(chg_a);
            chg_cnt[1] += int'(chg_b);
        end
    end

    // rx toggle source: explicit gap schedule first, else a fixed half-period (0 = stopped).
    initial begin
        int hcnt = 0;
        int gcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (tog_zero) begin
                tog  = 1'b0;
                hcnt = 0;
            end else if (gaps.size() != 0) begin
                gcnt++;
                if (gcnt >= gaps[0]) begin
                    tog  = ~tog;
                    gcnt = 0;
                    void'(gaps.pop_front());
                end
            end else if (half != 0) begin
                hcnt++;
                if (hcnt >= half) begin
                    tog  = ~tog;
                    hcnt = 0;
                end
            end
        end
    end

    initial begin
        int base_a, base_b, sel;
        tick(4);
        chk("rst_speed", int'(speed_a), 2);
        chk("rst_mii",   int'(mii_a),   0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_chg",   int'(chg_a),   0);
        rst_n = 1'b1;

        // 125 MHz rx_clk
        base_a = chg_cnt[0];
        half = 4;
        tick(60);
        chk("1g_speed", int'(speed_a), 2);
        chk("1g_mii",   int'(mii_a),   0);
        chk("1g_valid", int'(valid_a), 1);
        chk("1g_nochg", chg_cnt[0] - base_a, 0);

        // 25 MHz rx_clk
        base_a = chg_cnt[0];
        half = 20;
        tick(300);
        chk("100m_speed", int'(speed_a), 1);
        chk("100m_mii",   int'(mii_a),   1);
        chk("100m_chg",   chg_cnt[0] - base_a, 1);

        // force 11 while measuring 100M
        base_a = chg_cnt[0];
        force_en = 1'b1;
        force_speed = 2'b11;
        tick(1);
        chk("force_on_speed", int'(speed_a), 2);
        chk("force_on_chg",   int'(chg_a),   1);
        tick(40);
        chk("force_hold_speed", int'(speed_a), 2);
        chk("force_hold_valid", int'(valid_a), 1);
        force_en = 1'b0;
        tick(1);
        chk("force_off_speed", int'(speed_a), 1);
        chk("force_off_chg",   int'(chg_a),   1);
        tick(5);
        chk("force_chg_total", chg_cnt[0] - base_a, 2);

        // 2.5 MHz: one 10M confirmation pending, then reset mid-window
        half = 200;
        tick(200);
        chk("pend_speed", int'(speed_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_speed_a", int'(speed_a), 2);
        chk("midrst_mii_a",   int'(mii_a),   0);
        chk("midrst_valid_a", int'(valid_a), 0);
        chk("midrst_speed_b", int'(speed_b), 2);
        half = 0;
        tick(1);
        rst_n = 1'b1;
        tick(255);
        chk("10m_c255_speed", int'(speed_a), 2);
        chk("10m_c255_valid", int'(valid_a), 0);
        tick(1);
        chk("10m_c256_speed", int'(speed_a), 0);
        chk("10m_c256_mii",   int'(mii_a),   1);
        chk("10m_c256_chg",   int'(chg_a),   1);
        chk("10m_c256_valid", int'(valid_a), 1);

        // alternating single 100M / 1000M windows from a clean start
        tog_zero = 1'b1;
        rst_n = 1'b0;
        tick(3);
        tog_zero = 1'b0;
        rst_n = 1'b1;
        base_a = chg_cnt[0];
        base_b = chg_cnt[1];
        for (int g = 0; g < 8; g++) begin
            for (int e = 0; e < 3; e++) gaps.push_back((g % 2 == 0) ? 20 : 4);
        end
        for (int k = 0; k < 1000 && gaps.size() != 0; k++) tick(1);
        chk("alt_timeout", gaps.size(), 0);
        tick(12);
        chk("alt_a_chg",   chg_cnt[0] - base_a, 0);
        chk("alt_a_speed", int'(speed_a), 2);
        chk("alt_a_valid", int'(valid_a), 0);
        chk("alt_b_chg",   chg_cnt[1] - base_b, 8);
        chk("alt_b_speed", int'(speed_b), 2);

        // randomized segments
        for (int seg = 0; seg < 24; seg++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       half = 0;
                1:       half = 4;
                2:       half = 20;
                3:       half = 200;
                default: half = int'($urandom_range(2, 70));
            endcase
            force_en    = ($urandom_range(0, 3) == 0);
            force_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(int'($urandom_range(50, 400)));
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
